apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Simple-command to APB initiator: accepts one read/write request on a valid/ready
//  command port and runs one APB transfer: SETUP, then ACCESS until the slave is ready.
//  Returns read data or write-complete on a valid/ready response port.
//  Drives the peripheral-side APB slaves (GPIO etc.) from a core/wishbone-side requester.
// PARAMETERS
//  ADDR_W   32   APB address width
//  DATA_W   32   APB data width
//  STRB_W   4    byte-strobe width (DATA_W/8)
//  TIMEOUT  255  max ACCESS cycles with apb_rready low before abort; 0 = never abort
//  TO_W     8    timeout counter width, must hold TIMEOUT
// PORTS
//  clock       in   1       single clock, all logic on posedge
//  rst         in   1       synchronous reset, active-high
//  cmd_valid   in   1       request present
//  cmd_ready   out  1       bridge accepts request (IDLE only)
//  cmd_write   in   1       1 = write, 0 = read
//  cmd_addr    in   ADDR_W  target address
//  cmd_wdata   in   DATA_W  write data
//  cmd_strb    in   STRB_W  write byte strobes
//  rsp_valid   out  1       response present
//  rsp_ready   in   1       requester takes response
//  rsp_rdata   out  DATA_W  read data (0 for writes and on error)
//  rsp_err     out  1       transfer aborted by timeout
//  apb_addr    out  ADDR_W  APB address
//  apb_sel     out  1       APB select
//  apb_write   out  1       APB direction
//  apb_ena     out  1       APB enable (ACCESS phase)
//  apb_wdata   out  DATA_W  APB write data
//  apb_pstb    out  STRB_W  APB byte strobes
//  apb_rdata   in   DATA_W  APB read data
//  apb_rready  in   1       slave ready, completes ACCESS
// BEHAVIOUR
//  - Reset: state IDLE; apb_sel/apb_ena/apb_write=0; apb_addr/apb_wdata/apb_pstb=0;
//    rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout count=0. All APB outputs registered.
//  - cmd_ready = (state==IDLE) && !rst; combinational from state register.
//  - FSM: IDLE -(cmd_valid&&cmd_ready)-> SETUP -> ACCESS -(apb_rready|timeout)-> RESP
//    -(rsp_ready)-> IDLE. No bypass: one transfer per >=4 cycles.
//  - IDLE->SETUP edge: capture addr/write/wdata into APB regs; apb_sel=1, apb_ena=0.
//    Reads force apb_pstb=0 and apb_wdata=0.
//  - SETUP: exactly one cycle. Next edge apb_ena=1.
//  - ACCESS: apb_addr/write/wdata/pstb held stable. Edge with apb_rready=1: sample
//    apb_rdata into rsp_rdata (reads; writes load 0), rsp_err=0, drop sel/ena, rsp_valid=1.
//  - Timeout: counter clears entering ACCESS and increments each ACCESS cycle with
//    apb_rready=0. When it equals TIMEOUT (TIMEOUT!=0): same exit as above with rsp_err=1,
//    rsp_rdata=0. apb_rready on the same edge wins (normal completion, err=0).
//  - RESP: rsp_valid, rsp_rdata, rsp_err held until rsp_ready; cleared on handshake edge.
//    apb_sel/apb_ena stay 0. apb_addr holds its last value.
//  - cmd_* ignored outside IDLE; cmd_valid with cmd_ready=0 is not consumed.
//  - Reset mid-transfer: next edge forces IDLE, sel/ena=0, rsp_valid=0; transfer lost,
//    no response produced.
// STRUCTURE
//  - Shared package apb_pkg: FSM state enum (IDLE,SETUP,ACCESS,RESP), APB width
//    constants, peripheral offsets (GPO 8'h00, GPI 8'h04, GPID 8'h0C).
//  - One sub-module: apb_timeout_cnt (clear, enable, terminal-count flag, TO_W wide).
// TESTING
//  - Write 0x00 <- 0xA5A5_5A5A, strb 4'hF, rready tied 1: SETUP 1 cycle (sel=1,ena=0),
//    ACCESS 1 cycle, rsp_valid on 3rd edge after accept, rsp_rdata=0, err=0.
//  - Read 0x04, slave returns 0x1234_5678 with rready=1: rsp_rdata=0x1234_5678, pstb=0.
//  - Wait states: rready low 3 ACCESS cycles: ena held 4 cycles; addr/wdata stable.
//  - TIMEOUT=4, rready stuck 0: abort after 4 ACCESS cycles, rsp_err=1, rdata=0, sel=0.
//  - rsp_ready low 5 cycles: rsp held; cmd_ready=0 throughout; back-to-back cmds serialised.
//  - rst pulse during ACCESS: next edge sel=ena=0, rsp_valid=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM states, bus widths and
// the register offsets of the peripheral block it drives.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    localparam logic [7:0] GPO_OFS  = 8'h00;
    localparam logic [7:0] GPI_OFS  = 8'h04;
    localparam logic [7:0] GPID_OFS = 8'h0C;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB initiator signals of the bridge, bundled so the
// requester, the bridge and the peripheral side share one definition.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int STRB_W = APB_STRB_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] apb_addr;
    logic              apb_sel;
    logic              apb_write;
    logic              apb_ena;
    logic [DATA_W-1:0] apb_wdata;
    logic [STRB_W-1:0] apb_pstb;
    logic [DATA_W-1:0] apb_rdata;
    logic              apb_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  rsp_ready, apb_rdata, apb_rready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output apb_addr, apb_sel, apb_write, apb_ena, apb_wdata, apb_pstb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output rsp_ready, apb_rdata, apb_rready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  apb_addr, apb_sel, apb_write, apb_ena, apb_wdata, apb_pstb
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting on the slave; tc_o flags the cycle whose
// increment would reach TIMEOUT. TIMEOUT of 0 disables the flag.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clock,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB initiator: SETUP, ACCESS until the slave is
// ready (or the wait budget runs out), then hold the response until taken.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int STRB_W  = APB_STRB_W,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                clock,
    input  logic                rst,
    apb_master_bridge_if.master bus
);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] pstb_q, pstb_d;
    logic              sel_q, sel_d;
    logic              ena_q, ena_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic to_clr, to_en, to_tc;

    assign to_clr = (state_q == SETUP);
    assign to_en  = (state_q == ACCESS) && !bus.apb_rready;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clock (clock),
        .rst   (rst),
        .clr_i (to_clr),
        .en_i  (to_en),
        .tc_o  (to_tc)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        pstb_d      = pstb_q;
        sel_d       = sel_q;
        ena_d       = ena_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = SETUP;
                    addr_d  = bus.cmd_addr;
                    write_d = bus.cmd_write;
                    // Reads never present stale write data or strobes on the bus.
                    wdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    pstb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
                    sel_d   = 1'b1;
                    ena_d   = 1'b0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                ena_d   = 1'b1;
            end
            ACCESS: begin
                // A ready slave on the terminal-count edge still completes normally.
                if (bus.apb_rready || to_tc) begin
                    state_d     = RESP;
                    sel_d       = 1'b0;
                    ena_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    err_d       = !bus.apb_rready;
                    rdata_d     = (bus.apb_rready && !write_q) ? bus.apb_rdata : '0;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            pstb_q      <= '0;
            sel_q       <= 1'b0;
            ena_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            pstb_q      <= pstb_d;
            sel_q       <= sel_d;
            ena_q       <= ena_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.apb_addr  = addr_q;
    assign bus.apb_sel   = sel_q;
    assign bus.apb_write = write_q;
    assign bus.apb_ena   = ena_q;
    assign bus.apb_wdata = wdata_q;
    assign bus.apb_pstb  = pstb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scenario bench for apb_master_bridge: per-scenario tasks check bus timing,
// while a response monitor pops expected {err, rdata} from a scoreboard queue.
module tb_apb_master_bridge;
    import apb_pkg::*;

    logic clock = 1'b0;
    logic rst;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    logic [32:0] exp_q[$];

    apb_master_bridge_if bus ();

    apb_master_bridge #(
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clock) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            logic [32:0] e;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected got err=%0h rdata=%0h required=none", bus.rsp_err, bus.rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_err, bus.rsp_rdata} !== e)
                    $display("FAIL rsp_scoreboard got err=%0h rdata=%0h required err=%0h rdata=%0h",
                             bus.rsp_err, bus.rsp_rdata, e[32], e[31:0]);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.rsp_ready = 1'b0;
        bus.apb_rdata = '0; bus.apb_rready = 1'b0;
        repeat (2) tick();
        chk_cnt++;
        if ({bus.cmd_ready, bus.apb_sel, bus.apb_ena, bus.apb_write, bus.rsp_valid, bus.rsp_err} !== 6'b0)
            $display("FAIL reset_ctrl got=%b required=000000",
                     {bus.cmd_ready, bus.apb_sel, bus.apb_ena, bus.apb_write, bus.rsp_valid, bus.rsp_err});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.apb_addr, bus.apb_wdata, bus.apb_pstb, bus.rsp_rdata} !== 100'h0)
            $display("FAIL reset_data got addr=%0h wdata=%0h pstb=%0h rdata=%0h required all 0",
                     bus.apb_addr, bus.apb_wdata, bus.apb_pstb, bus.rsp_rdata);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_release_ready got=%b required=1", bus.cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_write;
        bus.rsp_ready = 1'b1; bus.apb_rready = 1'b1;
        drive_cmd(1'b1, {24'h0, GPO_OFS}, 32'hA5A5_5A5A, 4'hF);
        exp_q.push_back({1'b0, 32'h0});
        tick();
        bus.cmd_valid = 1'b0;
        chk_cnt++;
        if ({bus.apb_sel, bus.apb_ena, bus.apb_write, bus.cmd_ready} !== 4'b1010)
            $display("FAIL wr_setup_ctrl got=%b required=1010",
                     {bus.apb_sel, bus.apb_ena, bus.apb_write, bus.cmd_ready});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.apb_addr, bus.apb_wdata, bus.apb_pstb} !== {32'h0, 32'hA5A5_5A5A, 4'hF})
            $display("FAIL wr_setup_data got addr=%0h wdata=%0h pstb=%0h required 0/a5a55a5a/f",
                     bus.apb_addr, bus.apb_wdata, bus.apb_pstb);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({bus.apb_sel, bus.apb_ena, bus.rsp_valid} !== 3'b110)
            $display("FAIL wr_access got=%b required=110", {bus.apb_sel, bus.apb_ena, bus.rsp_valid});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({bus.rsp_valid, bus.apb_sel, bus.apb_ena, bus.rsp_err, bus.rsp_rdata} !== {4'b1000, 32'h0})
            $display("FAIL wr_resp got vld/sel/ena/err=%b rdata=%0h required 1000/0",
                     {bus.rsp_valid, bus.apb_sel, bus.apb_ena, bus.rsp_err}, bus.rsp_rdata);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01)
            $display("FAIL wr_idle got=%b required=01", {bus.rsp_valid, bus.cmd_ready});
        else pass_cnt++;
    endtask

    task automatic test_read;
        bus.rsp_ready = 1'b1; bus.apb_rready = 1'b1; bus.apb_rdata = 32'h1234_5678;
        drive_cmd(1'b0, {24'h0, GPI_OFS}, 32'hDEAD_BEEF, 4'hF);
        exp_q.push_back({1'b0, 32'h1234_5678});
        tick();
        bus.cmd_valid = 1'b0;
        chk_cnt++;
        if ({bus.apb_sel, bus.apb_ena, bus.apb_write} !== 3'b100)
            $display("FAIL rd_setup_ctrl got=%b required=100", {bus.apb_sel, bus.apb_ena, bus.apb_write});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.apb_addr, bus.apb_wdata, bus.apb_pstb} !== {32'h4, 32'h0, 4'h0})
            $display("FAIL rd_setup_data got addr=%0h wdata=%0h pstb=%0h required 4/0/0",
                     bus.apb_addr, bus.apb_wdata, bus.apb_pstb);
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'h1234_5678})
            $display("FAIL rd_resp got vld/err=%b rdata=%0h required 10/12345678",
                     {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_wait_states;
        int ena_cycles = 0;
        bus.rsp_ready = 1'b1; bus.apb_rready = 1'b0;
        drive_cmd(1'b1, {24'h0, GPID_OFS}, 32'h0BAD_F00D, 4'h3);
        exp_q.push_back({1'b0, 32'h0});
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 32'hFFFF_FFFF;
        tick();
        if (bus.apb_ena === 1'b1) ena_cycles++;
        repeat (3) begin
            tick();
            if (bus.apb_ena === 1'b1) ena_cycles++;
            chk_cnt++;
            if ({bus.apb_sel, bus.apb_ena, bus.rsp_valid, bus.apb_addr, bus.apb_wdata, bus.apb_pstb}
                !== {3'b110, 32'hC, 32'h0BAD_F00D, 4'h3})
                $display("FAIL wait_hold got sel/ena/vld=%b addr=%0h wdata=%0h pstb=%0h required 110/c/badf00d/3",
                         {bus.apb_sel, bus.apb_ena, bus.rsp_valid}, bus.apb_addr, bus.apb_wdata, bus.apb_pstb);
            else pass_cnt++;
        end
        bus.apb_rready = 1'b1;
        tick();
        chk_cnt++;
        if ({bus.rsp_valid, bus.rsp_err, bus.apb_sel, bus.apb_ena} !== 4'b1000)
            $display("FAIL wait_done got=%b required=1000",
                     {bus.rsp_valid, bus.rsp_err, bus.apb_sel, bus.apb_ena});
        else pass_cnt++;
        chk_cnt++;
        if (ena_cycles !== 4) $display("FAIL wait_ena_cycles got=%0d required=4", ena_cycles);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout;
        bus.rsp_ready = 1'b1; bus.apb_rready = 1'b0; bus.apb_rdata = 32'hFFFF_FFFF;
        drive_cmd(1'b0, {24'h0, GPI_OFS}, 32'h0, 4'h0);
        exp_q.push_back({1'b1, 32'h0});
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        repeat (3) begin
            tick();
            chk_cnt++;
            if ({bus.apb_ena, bus.rsp_valid} !== 2'b10)
                $display("FAIL to_waiting got ena/vld=%b required=10", {bus.apb_ena, bus.rsp_valid});
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if ({bus.rsp_valid, bus.rsp_err, bus.apb_sel, bus.apb_ena, bus.rsp_rdata} !== {4'b1100, 32'h0})
            $display("FAIL to_abort got vld/err/sel/ena=%b rdata=%0h required 1100/0",
                     {bus.rsp_valid, bus.rsp_err, bus.apb_sel, bus.apb_ena}, bus.rsp_rdata);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({bus.rsp_valid, bus.rsp_err, bus.cmd_ready} !== 3'b001)
            $display("FAIL to_idle got=%b required=001", {bus.rsp_valid, bus.rsp_err, bus.cmd_ready});
        else pass_cnt++;
        bus.apb_rready = 1'b1;
    endtask

    task automatic test_back_to_back;
        int n = 0;
        bus.rsp_ready = 1'b0; bus.apb_rready = 1'b1; bus.apb_rdata = 32'h1111_2222;
        drive_cmd(1'b1, {24'h0, GPO_OFS}, 32'h5555_AAAA, 4'hF);
        exp_q.push_back({1'b0, 32'h0});
        tick();
        drive_cmd(1'b0, {24'h0, GPI_OFS}, 32'h0, 4'h0);
        exp_q.push_back({1'b0, 32'h1111_2222});
        tick();
        tick();
        repeat (5) begin
            chk_cnt++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.apb_sel, bus.apb_ena, bus.rsp_err, bus.rsp_rdata, bus.apb_addr}
                !== {5'b10000, 32'h0, 32'h0})
                $display("FAIL b2b_hold got vld/rdy/sel/ena/err=%b rdata=%0h addr=%0h required 10000/0/0",
                         {bus.rsp_valid, bus.cmd_ready, bus.apb_sel, bus.apb_ena, bus.rsp_err},
                         bus.rsp_rdata, bus.apb_addr);
            else pass_cnt++;
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk_cnt++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01)
            $display("FAIL b2b_release got=%b required=01", {bus.rsp_valid, bus.cmd_ready});
        else pass_cnt++;
        tick();
        bus.cmd_valid = 1'b0;
        chk_cnt++;
        if ({bus.apb_sel, bus.apb_ena, bus.apb_write, bus.apb_addr} !== {3'b100, 32'h4})
            $display("FAIL b2b_second_setup got sel/ena/wr=%b addr=%0h required 100/4",
                     {bus.apb_sel, bus.apb_ena, bus.apb_write}, bus.apb_addr);
        else pass_cnt++;
        while (!bus.rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (bus.rsp_valid !== 1'b1) $display("FAIL b2b_second_rsp got=%b required=1 within 10 cycles", bus.rsp_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid;
        bus.rsp_ready = 1'b1; bus.apb_rready = 1'b0;
        drive_cmd(1'b1, {24'h0, GPO_OFS}, 32'h0000_0077, 4'h1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if ({bus.apb_sel, bus.apb_ena} !== 2'b11)
            $display("FAIL rstmid_access got=%b required=11", {bus.apb_sel, bus.apb_ena});
        else pass_cnt++;
        rst = 1'b1;
        tick();
        chk_cnt++;
        if ({bus.apb_sel, bus.apb_ena, bus.rsp_valid, bus.cmd_ready} !== 4'b0000)
            $display("FAIL rstmid_abort got=%b required=0000",
                     {bus.apb_sel, bus.apb_ena, bus.rsp_valid, bus.cmd_ready});
        else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL rstmid_ready got=%b required=1", bus.cmd_ready);
        else pass_cnt++;
        bus.apb_rready = 1'b1;
        repeat (6) tick();
        chk_cnt++;
        if ({bus.rsp_valid, bus.apb_sel} !== 2'b00)
            $display("FAIL rstmid_no_rsp got=%b required=00", {bus.rsp_valid, bus.apb_sel});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
